// File: rtl/rtc_bus_scheduler.sv
// rtc_bus_scheduler
//   Arbitrates the shared RTC bus transaction engine between the init, user-write
//   and periodic-read requester FSMs. Exactly one requester is granted at a time,
//   with a fixed priority of init > write > read and an idle gap after every grant.
//   An init sequence is forced after reset. Periodic read requests are generated
//   internally.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   init_req     level request to re-run initialization (rising edge is used)
//   wr_req       level request for a user write sequence (rising edge is used)
//   rd_en        enables periodic reads
//   done_init    one-cycle pulse from the init FSM when it has finished
//   done_wr      one-cycle pulse from the write FSM when it has finished
//   done_rd      one-cycle pulse from the read FSM when it has finished
//   gnt_init     init FSM owns the bus
//   gnt_wr       write FSM owns the bus
//   gnt_rd       read FSM owns the bus
//   mux_sel      bus mux select: 00 none, 01 init, 10 write, 11 read
//   busy         high in any grant or gap state
//   init_ok      at least one initialization completed without timeout
//   timeout_err  sticky; a grant was force-released by the watchdog
module rtc_bus_scheduler #(
    parameter int unsigned READ_PERIOD = 1000000,
    parameter int unsigned TIMEOUT     = 1023,
    parameter int unsigned GAP         = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_req,
    input  logic       wr_req,
    input  logic       rd_en,
    input  logic       done_init,
    input  logic       done_wr,
    input  logic       done_rd,
    output logic       gnt_init,
    output logic       gnt_wr,
    output logic       gnt_rd,
    output logic [1:0] mux_sel,
    output logic       busy,
    output logic       init_ok,
    output logic       timeout_err
);

    localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned PC_W = (READ_PERIOD > 1) ? $clog2(READ_PERIOD) : 1;
    localparam int unsigned GC_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [PC_W-1:0] PC_LAST  = PC_W'(READ_PERIOD - 1);
    localparam logic [GC_W-1:0] GAP_LAST = GC_W'(GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT_INIT,
        ST_GRANT_WR,
        ST_GRANT_RD,
        ST_GAP
    } state_t;

    state_t state, state_n;

    logic            run;
    logic            init_s, init_s_d, wr_s, wr_s_d;
    logic            init_pend, wr_pend, rd_pend;
    logic [WD_W-1:0] wdog;
    logic [PC_W-1:0] pcnt;
    logic [GC_W-1:0] gcnt;

    logic            done_cur;
    logic            in_grant;
    logic            wd_fire;
    logic            init_rise, wr_rise, rd_tick;
    logic            take_init, take_wr, take_rd;

    // Request edges are detected on already-sampled copies, so a request seen at
    // one edge raises its pending flag on the following edge.
    assign init_rise = init_s & ~init_s_d;
    assign wr_rise   = wr_s & ~wr_s_d;
    assign rd_tick   = (pcnt == PC_LAST) & rd_en & init_ok;

    assign take_init = (state == ST_IDLE) & (state_n == ST_GRANT_INIT);
    assign take_wr   = (state == ST_IDLE) & (state_n == ST_GRANT_WR);
    assign take_rd   = (state == ST_IDLE) & (state_n == ST_GRANT_RD);

    always_comb begin
        done_cur = 1'b0;
        in_grant = 1'b0;
        case (state)
            ST_GRANT_INIT: begin done_cur = done_init; in_grant = 1'b1; end
            ST_GRANT_WR:   begin done_cur = done_wr;   in_grant = 1'b1; end
            ST_GRANT_RD:   begin done_cur = done_rd;   in_grant = 1'b1; end
            default:       begin done_cur = 1'b0;      in_grant = 1'b0; end
        endcase
        // Release on the edge at which the watchdog would reach TIMEOUT, so a
        // grant is held for at most TIMEOUT cycles.
        wd_fire = in_grant & ~done_cur & (wdog == WD_LAST);
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                // run holds off arbitration for the first cycle after reset release.
                if (run) begin
                    if (init_pend)
                        state_n = ST_GRANT_INIT;
                    else if (wr_pend && init_ok)
                        state_n = ST_GRANT_WR;
                    else if (rd_pend && init_ok)
                        state_n = ST_GRANT_RD;
                end
            end
            ST_GRANT_INIT,
            ST_GRANT_WR,
            ST_GRANT_RD: begin
                if (done_cur || wd_fire)
                    state_n = ST_GAP;
            end
            ST_GAP: begin
                if (gcnt == GAP_LAST)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run         <= 1'b0;
            init_s      <= 1'b0;
            init_s_d    <= 1'b0;
            wr_s        <= 1'b0;
            wr_s_d      <= 1'b0;
            init_pend   <= 1'b1;
            wr_pend     <= 1'b0;
            rd_pend     <= 1'b0;
            wdog        <= '0;
            pcnt        <= '0;
            gcnt        <= '0;
            init_ok     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            run      <= 1'b1;
            init_s   <= init_req;
            init_s_d <= init_s;
            wr_s     <= wr_req;
            wr_s_d   <= wr_s;

            // A new request on the same edge as the grant that clears it wins.
            init_pend <= init_rise | (init_pend & ~take_init);
            wr_pend   <= wr_rise   | (wr_pend   & ~take_wr);
            rd_pend   <= rd_tick   | (rd_pend   & ~take_rd);

            if (pcnt == PC_LAST)
                pcnt <= '0;
            else
                pcnt <= pcnt + 1'b1;

            if (in_grant)
                wdog <= wdog + 1'b1;
            else
                wdog <= '0;

            if ((state == ST_GAP) && (state_n == ST_GAP))
                gcnt <= gcnt + 1'b1;
            else
                gcnt <= '0;

            if ((state == ST_GRANT_INIT) && done_init)
                init_ok <= 1'b1;
            if (wd_fire)
                timeout_err <= 1'b1;
        end
    end

    // Outputs are registered decodes of the next state, so they change on the
    // same edge as the state itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_init <= 1'b0;
            gnt_wr   <= 1'b0;
            gnt_rd   <= 1'b0;
            mux_sel  <= 2'b00;
            busy     <= 1'b0;
        end else begin
            gnt_init <= (state_n == ST_GRANT_INIT);
            gnt_wr   <= (state_n == ST_GRANT_WR);
            gnt_rd   <= (state_n == ST_GRANT_RD);
            busy     <= (state_n != ST_IDLE);
            case (state_n)
                ST_GRANT_INIT: mux_sel <= 2'b01;
                ST_GRANT_WR:   mux_sel <= 2'b10;
                ST_GRANT_RD:   mux_sel <= 2'b11;
                default:       mux_sel <= 2'b00;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// tb_rtc_bus_scheduler
//   Directed bench for rtc_bus_scheduler with READ_PERIOD=100, TIMEOUT=50, GAP=4.
//   cyc counts rising clock edges since the last reset release; outputs are
//   sampled 1 ns after each edge and inputs are changed at that point, so an
//   input set after edge n is first sampled at edge n+1.
module tb_rtc_bus_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       init_req, wr_req, rd_en;
    logic       done_init, done_wr, done_rd;
    logic       gnt_init, gnt_wr, gnt_rd;
    logic [1:0] mux_sel;
    logic       busy, init_ok, timeout_err;
    logic [5:0] obs;

    // obs = {gnt_init, gnt_wr, gnt_rd, mux_sel, busy}
    localparam logic [5:0] O_IDLE = 6'b000_00_0;
    localparam logic [5:0] O_INIT = 6'b100_01_1;
    localparam logic [5:0] O_WR   = 6'b010_10_1;
    localparam logic [5:0] O_RD   = 6'b001_11_1;
    localparam logic [5:0] O_GAP  = 6'b000_00_1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    assign obs = {gnt_init, gnt_wr, gnt_rd, mux_sel, busy};

    always #5 clk = ~clk;

    rtc_bus_scheduler #(
        .READ_PERIOD(100),
        .TIMEOUT(50),
        .GAP(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .init_req(init_req),
        .wr_req(wr_req),
        .rd_en(rd_en),
        .done_init(done_init),
        .done_wr(done_wr),
        .done_rd(done_rd),
        .gnt_init(gnt_init),
        .gnt_wr(gnt_wr),
        .gnt_rd(gnt_rd),
        .mux_sel(mux_sel),
        .busy(busy),
        .init_ok(init_ok),
        .timeout_err(timeout_err)
    );

    task automatic to_edge(input int n);
        while (cyc < n) begin
            @(posedge clk);
            cyc++;
            #1;
        end
    endtask

    task automatic release_reset;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        init_req = 1'b0; wr_req = 1'b0; rd_en = 1'b0;
        done_init = 1'b0; done_wr = 1'b0; done_rd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (obs !== O_IDLE) begin failures++; $display("FAIL reset_outputs got=%b exp=%b", obs, O_IDLE); end
        checks++; if (init_ok !== 1'b0) begin failures++; $display("FAIL reset_init_ok got=%b exp=0", init_ok); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
        release_reset();
    endtask

    task automatic test_init;
        to_edge(1);
        checks++; if (obs !== O_IDLE) begin failures++; $display("FAIL init_e1_idle got=%b exp=%b", obs, O_IDLE); end
        to_edge(2);
        checks++; if (obs !== O_INIT) begin failures++; $display("FAIL init_e2_grant got=%b exp=%b", obs, O_INIT); end
        to_edge(4); done_wr = 1'b1; to_edge(5); done_wr = 1'b0;
        checks++; if (obs !== O_INIT) begin failures++; $display("FAIL init_foreign_done got=%b exp=%b", obs, O_INIT); end
        to_edge(11);
        checks++; if (init_ok !== 1'b0) begin failures++; $display("FAIL init_ok_before_done got=%b exp=0", init_ok); end
        done_init = 1'b1; to_edge(12); done_init = 1'b0;
        checks++; if (obs !== O_GAP) begin failures++; $display("FAIL init_release got=%b exp=%b", obs, O_GAP); end
        checks++; if (init_ok !== 1'b1) begin failures++; $display("FAIL init_ok_after_done got=%b exp=1", init_ok); end
        for (int e = 13; e <= 15; e++) begin
            to_edge(e);
            checks++; if (obs !== O_GAP) begin failures++; $display("FAIL init_gap_e%0d got=%b exp=%b", e, obs, O_GAP); end
        end
        to_edge(16);
        checks++; if (obs !== O_IDLE) begin failures++; $display("FAIL init_gap_end got=%b exp=%b", obs, O_IDLE); end
        to_edge(20);
        checks++; if (obs !== O_IDLE) begin failures++; $display("FAIL init_no_spurious got=%b exp=%b", obs, O_IDLE); end
    endtask

    task automatic test_periodic_read;
        rd_en = 1'b1;
        to_edge(100);
        checks++; if (obs !== O_IDLE) begin failures++; $display("FAIL rd_tick_edge got=%b exp=%b", obs, O_IDLE); end
        to_edge(101);
        checks++; if (obs !== O_RD) begin failures++; $display("FAIL rd_grant got=%b exp=%b", obs, O_RD); end
        to_edge(105); done_rd = 1'b1; to_edge(106); done_rd = 1'b0;
        checks++; if (obs !== O_GAP) begin failures++; $display("FAIL rd_release got=%b exp=%b", obs, O_GAP); end
        // Back-to-back writes keep the bus busy across ticks 200 and 300.
        to_edge(187); wr_req = 1'b1; to_edge(188); wr_req = 1'b0;
        to_edge(190);
        checks++; if (obs !== O_WR) begin failures++; $display("FAIL coal_w1 got=%b exp=%b", obs, O_WR); end
        to_edge(209); wr_req = 1'b1; to_edge(210); wr_req = 1'b0;
        to_edge(234); done_wr = 1'b1; to_edge(235); done_wr = 1'b0;
        to_edge(240);
        checks++; if (obs !== O_WR) begin failures++; $display("FAIL coal_w2_beats_rd got=%b exp=%b", obs, O_WR); end
        to_edge(259); wr_req = 1'b1; to_edge(260); wr_req = 1'b0;
        to_edge(284); done_wr = 1'b1; to_edge(285); done_wr = 1'b0;
        to_edge(300);
        checks++; if (obs !== O_WR) begin failures++; $display("FAIL coal_w3 got=%b exp=%b", obs, O_WR); end
        to_edge(334); done_wr = 1'b1; to_edge(335); done_wr = 1'b0;
        to_edge(339);
        checks++; if (obs !== O_IDLE) begin failures++; $display("FAIL coal_idle got=%b exp=%b", obs, O_IDLE); end
        to_edge(340);
        checks++; if (obs !== O_RD) begin failures++; $display("FAIL coal_rd got=%b exp=%b", obs, O_RD); end
        to_edge(344); done_rd = 1'b1; to_edge(345); done_rd = 1'b0; rd_en = 1'b0;
        to_edge(350);
        checks++; if (obs !== O_IDLE) begin failures++; $display("FAIL coal_single_rd got=%b exp=%b", obs, O_IDLE); end
        to_edge(380);
        checks++; if (obs !== O_IDLE) begin failures++; $display("FAIL coal_quiet got=%b exp=%b", obs, O_IDLE); end
    endtask

    task automatic test_back_to_back;
        to_edge(400); rd_en = 1'b1;
        to_edge(498); wr_req = 1'b1; to_edge(499); wr_req = 1'b0;
        to_edge(500);
        checks++; if (obs !== O_IDLE) begin failures++; $display("FAIL b2b_pre got=%b exp=%b", obs, O_IDLE); end
        done_wr = 1'b1; to_edge(501); done_wr = 1'b0;
        checks++; if (obs !== O_WR) begin failures++; $display("FAIL b2b_wr_first got=%b exp=%b", obs, O_WR); end
        to_edge(502);
        checks++; if (obs !== O_WR) begin failures++; $display("FAIL b2b_entry_done got=%b exp=%b", obs, O_WR); end
        to_edge(509); done_wr = 1'b1; to_edge(510); done_wr = 1'b0;
        checks++; if (obs !== O_GAP) begin failures++; $display("FAIL b2b_wr_release got=%b exp=%b", obs, O_GAP); end
        to_edge(514);
        checks++; if (obs !== O_IDLE) begin failures++; $display("FAIL b2b_before_rd got=%b exp=%b", obs, O_IDLE); end
        to_edge(515);
        checks++; if (obs !== O_RD) begin failures++; $display("FAIL b2b_rd_gap got=%b exp=%b", obs, O_RD); end
        to_edge(519); done_rd = 1'b1; to_edge(520); done_rd = 1'b0;
    endtask

    task automatic test_timeout;
        to_edge(548); wr_req = 1'b1; to_edge(549); wr_req = 1'b0;
        to_edge(551);
        checks++; if (obs !== O_WR) begin failures++; $display("FAIL to_grant got=%b exp=%b", obs, O_WR); end
        to_edge(600);
        checks++; if (obs !== O_WR) begin failures++; $display("FAIL to_held_50 got=%b exp=%b", obs, O_WR); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_err_early got=%b exp=0", timeout_err); end
        to_edge(601);
        checks++; if (obs !== O_GAP) begin failures++; $display("FAIL to_release got=%b exp=%b", obs, O_GAP); end
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_err_set got=%b exp=1", timeout_err); end
        to_edge(602); done_rd = 1'b1; to_edge(603); done_rd = 1'b0;
        to_edge(605);
        checks++; if (obs !== O_IDLE) begin failures++; $display("FAIL to_gap_done_ignored got=%b exp=%b", obs, O_IDLE); end
        to_edge(606);
        checks++; if (obs !== O_RD) begin failures++; $display("FAIL to_next_rd got=%b exp=%b", obs, O_RD); end
        to_edge(610); done_rd = 1'b1; to_edge(611); done_rd = 1'b0;
        checks++; if (obs !== O_GAP) begin failures++; $display("FAIL to_rd_release got=%b exp=%b", obs, O_GAP); end
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_err_sticky got=%b exp=1", timeout_err); end
    endtask

    task automatic test_init_rerun;
        to_edge(701);
        checks++; if (obs !== O_RD) begin failures++; $display("FAIL rerun_rd got=%b exp=%b", obs, O_RD); end
        to_edge(704); init_req = 1'b1; to_edge(705); init_req = 1'b0; rd_en = 1'b0;
        checks++; if (obs !== O_RD) begin failures++; $display("FAIL rerun_rd_kept got=%b exp=%b", obs, O_RD); end
        to_edge(709); done_rd = 1'b1; to_edge(710); done_rd = 1'b0;
        to_edge(714);
        checks++; if (obs !== O_IDLE) begin failures++; $display("FAIL rerun_idle got=%b exp=%b", obs, O_IDLE); end
        to_edge(715);
        checks++; if (obs !== O_INIT) begin failures++; $display("FAIL rerun_init got=%b exp=%b", obs, O_INIT); end
        to_edge(719); wr_req = 1'b1; to_edge(720); wr_req = 1'b0;
        to_edge(729); done_init = 1'b1; to_edge(730); done_init = 1'b0;
        to_edge(734);
        checks++; if (obs !== O_IDLE) begin failures++; $display("FAIL rerun_wr_wait got=%b exp=%b", obs, O_IDLE); end
        to_edge(735);
        checks++; if (obs !== O_WR) begin failures++; $display("FAIL rerun_wr_held got=%b exp=%b", obs, O_WR); end
        checks++; if (init_ok !== 1'b1) begin failures++; $display("FAIL rerun_init_ok got=%b exp=1", init_ok); end
        to_edge(739); done_wr = 1'b1; to_edge(740); done_wr = 1'b0;
    endtask

    task automatic test_reset_mid_grant;
        to_edge(759); wr_req = 1'b1; rd_en = 1'b1;
        to_edge(762);
        checks++; if (obs !== O_WR) begin failures++; $display("FAIL rst_pre_grant got=%b exp=%b", obs, O_WR); end
        to_edge(765);
        #3 reset = 1'b1;
        #1;
        checks++; if (obs !== O_IDLE) begin failures++; $display("FAIL rst_async_outputs got=%b exp=%b", obs, O_IDLE); end
        checks++; if ({init_ok, timeout_err} !== 2'b00) begin failures++; $display("FAIL rst_async_flags got=%b exp=00", {init_ok, timeout_err}); end
        repeat (2) @(posedge clk);
        release_reset();
        to_edge(1);
        checks++; if (obs !== O_IDLE) begin failures++; $display("FAIL rst_e1_idle got=%b exp=%b", obs, O_IDLE); end
        to_edge(2);
        checks++; if (obs !== O_INIT) begin failures++; $display("FAIL rst_init_first got=%b exp=%b", obs, O_INIT); end
        to_edge(11); done_init = 1'b1; to_edge(12); done_init = 1'b0;
        checks++; if (init_ok !== 1'b1) begin failures++; $display("FAIL rst_init_ok got=%b exp=1", init_ok); end
        to_edge(16);
        checks++; if (obs !== O_IDLE) begin failures++; $display("FAIL rst_wr_wait got=%b exp=%b", obs, O_IDLE); end
        to_edge(17);
        checks++; if (obs !== O_WR) begin failures++; $display("FAIL rst_wr_after_init got=%b exp=%b", obs, O_WR); end
        wr_req = 1'b0;
        to_edge(21); done_wr = 1'b1; to_edge(22); done_wr = 1'b0;
        checks++; if (obs !== O_GAP) begin failures++; $display("FAIL rst_wr_release got=%b exp=%b", obs, O_GAP); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_periodic_read();
        test_back_to_back();
        test_timeout();
        test_init_rerun();
        test_reset_mid_grant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
